// File: rtl/mux_memoria_nx1_param_pkg.sv
// mux_memoria_pkg: shared mode encodings and selector width helper for the N-to-1 registered mux
package mux_memoria_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR = 1'b1;
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/mux_memoria_nx1_param_if.sv
// mux_memoria_nx1_param_if: producer/consumer bundle of the N-to-1 registered mux
interface mux_memoria_nx1_param_if
  import mux_memoria_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int DATA_W = 4
);
  localparam int SEL_W = sel_width(N_CH);
  logic mode;
  logic [SEL_W-1:0] selector;
  logic [N_CH-1:0] valid_in;
  logic [N_CH*DATA_W-1:0] data_in;
  logic ready_in;
  logic [N_CH-1:0] ready_out;
  logic valid_out;
  logic [DATA_W-1:0] data_out;
  logic [SEL_W-1:0] sel_out;
  modport master (
    output mode, selector, valid_in, data_in, ready_in,
    input ready_out, valid_out, data_out, sel_out
  );
  modport slave (
    input mode, selector, valid_in, data_in, ready_in,
    output ready_out, valid_out, data_out, sel_out
  );
endinterface

// File: rtl/mux_memoria_nx1_param_rr_priority_pick.sv
// rr_priority_pick: rotate-priority encoder, searches ptr+1 .. ptr (mod N_CH) for the first request
module rr_priority_pick
  import mux_memoria_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int SEL_W = sel_width(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);
  // farthest candidate first so the nearest one after ptr overwrites it
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N_CH; i >= 1; i--) begin
      if (req[(int'(ptr) + i) % N_CH]) begin
        idx = SEL_W'((int'(ptr) + i) % N_CH);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_memoria_nx1_param.sv
// mux_memoria_nx1_param: N-to-1 valid/ready mux with registered output memory and fixed or round-robin grant
module mux_memoria_nx1_param
  import mux_memoria_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int DATA_W = 4
) (
  input logic clk,
  input logic reset_L,
  mux_memoria_nx1_param_if.slave bus
);
  localparam int SEL_W = sel_width(N_CH);
  logic [SEL_W-1:0] ptr, rr_idx, g;
  logic rr_any, fix_ok, grant, load;
  rr_priority_pick #(.N_CH(N_CH), .SEL_W(SEL_W)) u_pick (
    .req(bus.valid_in),
    .ptr(ptr),
    .idx(rr_idx),
    .any(rr_any)
  );
  // an out-of-range selector is simply a channel that is never valid
  always_comb begin
    fix_ok = (int'(bus.selector) < N_CH) && bus.valid_in[bus.selector];
    grant = (bus.mode == MODE_RR) ? rr_any : fix_ok;
    g = (bus.mode == MODE_RR) ? rr_idx : bus.selector;
    load = !bus.valid_out || bus.ready_in;
    bus.ready_out = (load && grant) ? ({{(N_CH-1){1'b0}}, 1'b1} << g) : '0;
  end
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      bus.valid_out <= 1'b0;
      bus.data_out <= '0;
      bus.sel_out <= '0;
      ptr <= SEL_W'(N_CH - 1);
    end else if (load) begin
      bus.valid_out <= grant;
      if (grant) begin
        bus.data_out <= bus.data_in[g*DATA_W +: DATA_W];
        bus.sel_out <= g;
        ptr <= g;
      end
    end
  end
endmodule

// File: tb/tb_mux_memoria_nx1_param.sv
// tb_mux_memoria_nx1_param: directed and randomized checks of the registered N-to-1 mux against a behavioural model
module tb_mux_memoria_nx1_param;
  import mux_memoria_pkg::*;
  logic clk = 1'b0;
  logic reset_L;
  always #5 clk = ~clk;
  mux_memoria_nx1_param_if #(.N_CH(4), .DATA_W(4)) b4 ();
  mux_memoria_nx1_param_if #(.N_CH(5), .DATA_W(8)) b5 ();
  mux_memoria_nx1_param #(.N_CH(4), .DATA_W(4)) dut4 (.clk(clk), .reset_L(reset_L), .bus(b4.slave));
  mux_memoria_nx1_param #(.N_CH(5), .DATA_W(8)) dut5 (.clk(clk), .reset_L(reset_L), .bus(b5.slave));
  int errs = 0;
  int checks = 0;
  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // model of the 4-channel instance: output slot contents plus the last granted channel
  bit m_valid;
  int m_data, m_sel, m_ptr;
  bit [3:0] m_xfer;
  function automatic int grant4();
    if (b4.mode == MODE_RR) begin
      for (int d = 1; d <= 4; d++)
        if (b4.valid_in[(m_ptr + d) % 4] === 1'b1) return (m_ptr + d) % 4;
      return -1;
    end
    return (b4.valid_in[b4.selector] === 1'b1) ? int'(b4.selector) : -1;
  endfunction
  always @(posedge clk or negedge reset_L) begin
    int g;
    if (!reset_L) begin
      m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 3; m_xfer = 0;
    end else begin
      g = grant4();
      m_xfer = 0;
      if (!m_valid || b4.ready_in) begin
        m_valid = (g >= 0);
        if (g >= 0) begin
          m_data = int'(b4.data_in[g*4 +: 4]);
          m_sel = g; m_ptr = g; m_xfer = 4'(1 << g);
        end
      end
    end
  end
  always @(negedge clk) begin
    int g;
    g = grant4();
    chk("model_ready_out", b4.ready_out, ((!m_valid || b4.ready_in) && g >= 0) ? (1 << g) : 0);
    chk("model_valid_out", b4.valid_out, int'(m_valid));
    chk("model_data_out", b4.data_out, m_data);
    chk("model_sel_out", b4.sel_out, m_sel);
  end
  initial begin
    int es[5];
    int s5[10];
    bit [4:0] seen;
    es = '{0, 1, 2, 3, 0};
    reset_L = 1'b1;
    b4.mode = MODE_FIXED; b4.selector = '0; b4.valid_in = '0; b4.data_in = '0; b4.ready_in = 1'b0;
    b5.mode = MODE_FIXED; b5.selector = '0; b5.valid_in = '0; b5.data_in = '0; b5.ready_in = 1'b0;
    #1 reset_L = 1'b0;
    #1;
    chk("reset_valid", b4.valid_out, 0);
    chk("reset_data", b4.data_out, 0);
    chk("reset_sel", b4.sel_out, 0);
    @(posedge clk);
    #2 reset_L = 1'b1;
    b4.selector = 2'd2; b4.valid_in = 4'b0100; b4.data_in = 16'h0A00; b4.ready_in = 1'b1;
    #1 chk("fixed_ready_out", b4.ready_out, 4'b0100);
    step();
    chk("fixed_valid", b4.valid_out, 1);
    chk("fixed_data", b4.data_out, 4'hA);
    chk("fixed_sel", b4.sel_out, 2);
    b4.selector = 2'd1;
    #1 chk("hold_ready_out", b4.ready_out, 0);
    step();
    chk("hold_valid", b4.valid_out, 0);
    chk("hold_data", b4.data_out, 4'hA);
    chk("hold_sel", b4.sel_out, 2);
    b4.selector = 2'd2;
    step();
    b4.ready_in = 1'b0; b4.valid_in = 4'b1111; b4.data_in = 16'h5631;
    repeat (3) begin
      #1 chk("bp_ready_out", b4.ready_out, 0);
      step();
      chk("bp_valid", b4.valid_out, 1);
      chk("bp_data", b4.data_out, 4'hA);
    end
    b4.ready_in = 1'b1;
    #1 chk("bp_release_ready_out", b4.ready_out, 4'b0100);
    step();
    chk("bp_release_data", b4.data_out, 6);
    #2 reset_L = 1'b0;
    #1;
    chk("async_reset_valid", b4.valid_out, 0);
    chk("async_reset_data", b4.data_out, 0);
    chk("async_reset_sel", b4.sel_out, 0);
    @(posedge clk);
    #2 reset_L = 1'b1;
    b4.mode = MODE_RR; b4.valid_in = 4'b1111; b4.data_in = 16'h4321;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_sel", b4.sel_out, es[i]);
      chk("rr_data", b4.data_out, es[i] + 1);
    end
    step();
    chk("rr_ptr1_sel", b4.sel_out, 1);
    b4.valid_in = 4'b1010;
    #1 chk("rr_skip_ready3", b4.ready_out, 4'b1000);
    step();
    chk("rr_skip_sel3", b4.sel_out, 3);
    #1 chk("rr_skip_ready1", b4.ready_out, 4'b0010);
    step();
    chk("rr_skip_sel1", b4.sel_out, 1);
    for (int c = 0; c < 400; c++) begin
      b4.mode = logic'($urandom_range(0, 1));
      b4.selector = 2'($urandom_range(0, 3));
      b4.ready_in = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 4; k++) begin
        if (m_xfer[k] || !b4.valid_in[k]) begin
          b4.valid_in[k] = ($urandom_range(0, 9) < 6);
          b4.data_in[k*4 +: 4] = 4'($urandom);
        end
      end
      if ($urandom_range(0, 99) == 0) begin
        #1 reset_L = 1'b0;
        #2 reset_L = 1'b1;
      end
      step();
    end
    b5.mode = MODE_RR; b5.valid_in = 5'h1f; b5.ready_in = 1'b1;
    for (int k = 0; k < 5; k++) b5.data_in[k*8 +: 8] = 8'(8'h10 + k);
    for (int i = 0; i < 10; i++) begin
      step();
      s5[i] = int'(b5.sel_out);
      chk("n5_data", b5.data_out, 8'h10 + s5[i]);
    end
    chk("n5_first_sel", s5[0], 0);
    for (int w = 0; w < 2; w++) begin
      seen = '0;
      for (int i = 0; i < 5; i++) seen[s5[w*5 + i]] = 1'b1;
      chk("n5_fair_window", seen, 5'h1f);
    end
    b5.mode = MODE_FIXED; b5.selector = 3'd6;
    #1 chk("n5_sel6_ready_out", b5.ready_out, 0);
    step();
    chk("n5_sel6_valid", b5.valid_out, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mux_memoria_nx1_param.md
# mux_memoria_nx1_param

Parametrised N-to-1 multiplexer with per-channel valid, registered output memory, downstream backpressure and selectable fixed-select or round-robin arbitration. It generalises the cascaded 4x1/4-bit registered valid muxes into a single-stage block. It sits between N producer channels and one consumer in the validation-bits datapath. Each accepted word appears on the output one cycle later with its source channel index.

## Interface
Parameters:
- N_CH, 4, number of input channels (>= 2)
- DATA_W, 4, data width per channel
- SEL_W, $clog2(N_CH), selector/index width (derived, not overridden)

Ports:
- clk  input  1  single clock, rising edge
- reset_L  input  1  asynchronous, active-low reset
- mode  input  1  0 = fixed select, 1 = round-robin
- selector  input  SEL_W  channel to forward in fixed mode
- valid_in  input  N_CH  per-channel valid
- data_in  input  N_CH*DATA_W  flattened; channel k at [k*DATA_W +: DATA_W]
- ready_in  input  1  consumer ready
- ready_out  output  N_CH  per-channel accept, one-hot or zero
- valid_out  output  1  registered output valid
- data_out  output  DATA_W  registered output data
- sel_out  output  SEL_W  channel index of the word in data_out

## Operation
- load = !valid_out || ready_in; output slot is free or being drained this cycle.
- Grant g, combinational:
  - fixed mode: g = selector if selector < N_CH and valid_in[selector]; else no grant.
  - RR mode: first k with valid_in[k], searching ptr+1, ptr+2, ... mod N_CH (ptr itself searched last); no grant if valid_in == 0.
- ready_out[g] = load && grant; all other bits 0. ready_out depends combinationally on ready_in.
- Transfer on channel k is valid_in[k] && ready_out[k]. A producer holds data until it transfers.
- On clk edge with load && grant:
  - data_out <= channel g data
  - valid_out <= 1
  - sel_out <= g
  - ptr <= g (updated in both modes)
- On load && no grant:
  - valid_out <= 0
  - data_out and sel_out hold their last values (memory behaviour)
  - ptr holds
- On !load (valid_out=1, ready_in=0): all registers hold and ready_out = 0.
- A mode change takes effect in the same cycle. ptr is not cleared by a mode change.

## Timing
- Reset (reset_L=0, async, immediate): valid_out=0, data_out=0, sel_out=0, ptr=N_CH-1. The first RR search therefore starts at channel 0.
- Release of reset is synchronous to the next clk edge; the first load can occur on that edge.
- Latency: 1 cycle from transfer to valid_out/data_out.
- Throughput: 1 word/cycle while ready_in=1.
- Reset mid-transfer discards the in-flight word. No channel is considered accepted in the reset cycle.
- RR fairness: with all channels continuously valid and ready_in=1, each channel is granted exactly once in every N_CH consecutive loads.
- selector out of range (N_CH not a power of 2) behaves as an invalid channel.

## Structure
- Package mux_memoria_pkg holds:
  - MODE_FIXED = 1'b0 and MODE_RR = 1'b1
  - a function computing SEL_W from N_CH
- One sub-module, rr_priority_pick: a combinational rotate-priority encoder (inputs: request vector and ptr; outputs: grant index and any-grant flag). It is used only in RR mode.
- The top level contains:
  - the fixed/RR grant select
  - the ready_out decode
  - the output register, ptr register and load logic

## Test plan
Default parameters (N_CH=4, DATA_W=4) unless noted.
- Reset: assert reset_L=0 between clk edges while valid_out=1 and data_out=4'hA -> valid_out=0, data_out=0, sel_out=0 immediately, with no clk edge.
- Fixed select: mode=0, selector=2, valid_in=4'b0100, channel 2 data=4'hA, ready_in=1 -> ready_out=4'b0100; next edge gives valid_out=1, data_out=4'hA, sel_out=2.
- Memory hold: then selector=1, valid_in=4'b0100 -> ready_out=0; next edge gives valid_out=0, data_out=4'hA, sel_out=2.
- Backpressure: valid_out=1, ready_in=0, valid_in=4'b1111 -> ready_out=0 and outputs unchanged for 3 cycles. Raising ready_in=1 loads the next word on the following edge.
- Round-robin: mode=1 after reset, valid_in=4'b1111, ready_in=1, channel k data=k+1 -> sel_out sequence 0,1,2,3,0 and data_out sequence 1,2,3,4,1.
- RR skip and parameter sweep:
  - valid_in=4'b1010 with ptr=1 -> grants 3 then 1.
  - Repeat the fairness check with N_CH=5, DATA_W=8 -> each channel granted once per 5 loads; selector=6 in fixed mode gives no grant.
